// File: rtl/barrel_thread_scheduler_if.sv
// Fetch scheduler control/status bundle.
// master: the side that drives thread events (core control, testbench).
// slave : the scheduler itself.
interface barrel_thread_scheduler_if #(
   parameter int NUM_THREADS  = 8,
   parameter int BITS_THREADS = $clog2(NUM_THREADS)
);
   logic                    start;
   logic [NUM_THREADS-1:0]  start_mask;
   logic                    halt_valid;
   logic [BITS_THREADS-1:0] halt_tid;
   logic                    block_valid;
   logic [BITS_THREADS-1:0] block_tid;
   logic                    wake_valid;
   logic [BITS_THREADS-1:0] wake_tid;
   logic                    stall;
   logic [BITS_THREADS-1:0] tid_f;
   logic                    issue_valid;
   logic [NUM_THREADS-1:0]  active_mask;
   logic [NUM_THREADS-1:0]  blocked_mask;
   logic                    all_halted;

   modport master (
      output start, start_mask,
      output halt_valid, halt_tid,
      output block_valid, block_tid,
      output wake_valid, wake_tid,
      output stall,
      input  tid_f, issue_valid, active_mask, blocked_mask, all_halted
   );

   modport slave (
      input  start, start_mask,
      input  halt_valid, halt_tid,
      input  block_valid, block_tid,
      input  wake_valid, wake_tid,
      input  stall,
      output tid_f, issue_valid, active_mask, blocked_mask, all_halted
   );
endinterface

// File: rtl/barrel_thread_scheduler.sv
// Barrel-core fetch thread scheduler.
// Picks one thread per advancing cycle, round-robin over threads that are
// active, not blocked on a long-latency op and past their pipeline cooldown.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | out of reset, no thread ever started, no issue
//   S_RUN  | at least one thread active, issuing
//   S_DONE | every thread has halted; all_halted high, no issue
module barrel_thread_scheduler #(
   parameter int NUM_THREADS = 8,
   parameter int PIPE_DEPTH  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   barrel_thread_scheduler_if.slave  bus
);
   localparam int BITS_THREADS = $clog2(NUM_THREADS);
   localparam int COOL_W       = $clog2(PIPE_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_THREADS-1:0]  active_q, active_d;
   logic [NUM_THREADS-1:0]  blocked_q, blocked_d;
   logic [COOL_W-1:0]       cool_q [NUM_THREADS];
   logic [COOL_W-1:0]       cool_d [NUM_THREADS];
   logic [BITS_THREADS-1:0] tid_q, tid_d;
   logic [BITS_THREADS-1:0] last_q, last_d;
   logic                    issue_q, issue_d;

   logic [NUM_THREADS-1:0]  eligible;
   logic                    found;
   logic [BITS_THREADS-1:0] sel;
   logic                    start_ok;
   logic                    halt_hit;
   logic                    issue_en;

   assign start_ok = bus.start && (bus.start_mask != '0);
   // A halt only matters for a thread that is actually running.
   assign halt_hit = bus.halt_valid && active_q[bus.halt_tid];

   // Thread mask updates; these track events even while the pipe is stalled.
   always_comb begin
      active_d  = active_q;
      blocked_d = blocked_q;
      if (bus.start) begin
         active_d = active_d | bus.start_mask;
      end
      if (halt_hit) begin
         active_d[bus.halt_tid] = 1'b0;
      end
      if (bus.wake_valid) begin
         blocked_d[bus.wake_tid] = 1'b0;
      end
      // Block after wake so a same-cycle block/wake leaves the thread blocked.
      if (bus.block_valid) begin
         blocked_d[bus.block_tid] = 1'b1;
      end
      if (halt_hit) begin
         blocked_d[bus.halt_tid] = 1'b0;
      end
   end

   // Run-state FSM next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_ok) state_d = S_RUN;
         S_RUN:  if (active_d == '0) state_d = S_DONE;
         S_DONE: if (start_ok) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-thread eligibility from registered state only.
   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         eligible[i] = active_q[i] & ~blocked_q[i] & (cool_q[i] == '0);
      end
   end

   // Round-robin scan starting just after the last issued tid. Walking the
   // offsets from far to near lets the nearest eligible thread win; offset
   // NUM_THREADS wraps back onto last itself.
   always_comb begin
      logic [BITS_THREADS-1:0] idx;
      idx   = last_q;
      found = 1'b0;
      sel   = last_q;
      for (int off = NUM_THREADS; off >= 1; off--) begin
         idx = last_q + BITS_THREADS'(off);
         if (eligible[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Issue only while running and not about to drop into DONE.
   assign issue_en = (state_q == S_RUN) && (state_d == S_RUN) && !bus.stall;

   // Issue, pointer and cooldown next values.
   always_comb begin
      tid_d   = tid_q;
      issue_d = issue_q;
      last_d  = last_q;
      for (int i = 0; i < NUM_THREADS; i++) begin
         cool_d[i] = cool_q[i];
      end
      if (!bus.stall) begin
         issue_d = 1'b0;
         for (int i = 0; i < NUM_THREADS; i++) begin
            if (cool_q[i] != '0) begin
               cool_d[i] = cool_q[i] - COOL_W'(1);
            end
         end
         if (issue_en && found) begin
            issue_d     = 1'b1;
            tid_d       = sel;
            last_d      = sel;
            cool_d[sel] = COOL_W'(PIPE_DEPTH - 1);
         end
      end
      if (halt_hit) begin
         cool_d[bus.halt_tid] = '0;
      end
      // A stalled bubble must never carry a stale issue into IDLE/DONE.
      if (state_d != S_RUN) begin
         issue_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         active_q  <= '0;
         blocked_q <= '0;
         tid_q     <= '0;
         issue_q   <= 1'b0;
         last_q    <= BITS_THREADS'(NUM_THREADS - 1);
         for (int i = 0; i < NUM_THREADS; i++) begin
            cool_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         blocked_q <= blocked_d;
         tid_q     <= tid_d;
         issue_q   <= issue_d;
         last_q    <= last_d;
         for (int i = 0; i < NUM_THREADS; i++) begin
            cool_q[i] <= cool_d[i];
         end
      end
   end

   assign bus.tid_f        = tid_q;
   assign bus.issue_valid  = issue_q;
   assign bus.active_mask  = active_q;
   assign bus.blocked_mask = blocked_q;
   assign bus.all_halted   = (state_q == S_DONE);

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// Scenario bench for the barrel thread scheduler (8 threads, depth 5).
module tb_barrel_thread_scheduler;
   logic clk;
   logic rst_n;

   barrel_thread_scheduler_if #(.NUM_THREADS(8)) bus ();

   barrel_thread_scheduler #(.NUM_THREADS(8), .PIPE_DEPTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       v;
      logic [2:0] tid;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [2:0] exp_last;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.start_mask  = '0;
      bus.halt_valid  = 1'b0;
      bus.halt_tid    = '0;
      bus.block_valid = 1'b0;
      bus.block_tid   = '0;
      bus.wake_valid  = 1'b0;
      bus.wake_tid    = '0;
      bus.stall       = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      n_cmp++; if (bus.tid_f !== 3'd0) begin n_bad++; $display("FAIL reset_tid got=%0d want=0", bus.tid_f); end
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue got=%b want=0", bus.issue_valid); end
      n_cmp++; if (bus.active_mask !== 8'h00) begin n_bad++; $display("FAIL reset_active got=%h want=00", bus.active_mask); end
      n_cmp++; if (bus.blocked_mask !== 8'h00) begin n_bad++; $display("FAIL reset_blocked got=%h want=00", bus.blocked_mask); end
      n_cmp++; if (bus.all_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b want=0", bus.all_halted); end
      step();
      rst_n = 1'b1;
      step();
      step();
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL idle_no_issue got=%b want=0", bus.issue_valid); end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bus.start = 1'b1;
      bus.start_mask = 8'hFF;
      step();
      bus.start = 1'b0;
      bus.start_mask = 8'h00;
      n_cmp++; if (bus.active_mask !== 8'hFF) begin n_bad++; $display("FAIL rr_active got=%h want=ff", bus.active_mask); end
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL rr_first_bubble got=%b want=0", bus.issue_valid); end
      for (int k = 0; k < 9; k++) sb.push_back('{v: 1'b1, tid: 3'(k % 8)});
      for (int k = 0; k < 9; k++) begin
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({bus.issue_valid, bus.tid_f} !== e) begin
            n_bad++;
            $display("FAIL rr_seq[%0d] got v=%b tid=%0d want v=%b tid=%0d", k, bus.issue_valid, bus.tid_f, e.v, e.tid);
         end
      end
      n_cmp++; if (bus.all_halted !== 1'b0) begin n_bad++; $display("FAIL rr_halted got=%b want=0", bus.all_halted); end
      exp_last = 3'd0;
   endtask

   task automatic test_block_wake();
      exp_t e;
      logic mb3;
      logic [2:0] s;
      mb3 = 1'b0;
      for (int j = 0; j < 20; j++) begin
         bus.block_valid = (j == 0);
         bus.block_tid   = 3'd3;
         bus.wake_valid  = (j == 10);
         bus.wake_tid    = 3'd3;
         s = exp_last + 3'd1;
         if (s == 3'd3 && mb3) s = 3'd4;
         sb.push_back('{v: 1'b1, tid: s});
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({bus.issue_valid, bus.tid_f} !== e) begin
            n_bad++;
            $display("FAIL blk_seq[%0d] got v=%b tid=%0d want v=%b tid=%0d", j, bus.issue_valid, bus.tid_f, e.v, e.tid);
         end
         exp_last = s;
         if (j == 0) mb3 = 1'b1;
         if (j == 10) mb3 = 1'b0;
         if (j == 1) begin
            n_cmp++; if (bus.blocked_mask !== 8'h08) begin n_bad++; $display("FAIL blk_mask got=%h want=08", bus.blocked_mask); end
         end
         if (j == 11) begin
            n_cmp++; if (bus.blocked_mask !== 8'h00) begin n_bad++; $display("FAIL wake_mask got=%h want=00", bus.blocked_mask); end
         end
      end
      bus.block_valid = 1'b0;
      bus.wake_valid  = 1'b0;
   endtask

   task automatic test_stall();
      exp_t e;
      logic stl;
      for (int j = 0; j < 10; j++) begin
         stl = (j >= 2 && j < 6);
         bus.stall = stl;
         if (stl) sb.push_back('{v: 1'b1, tid: exp_last});
         else begin
            exp_last = exp_last + 3'd1;
            sb.push_back('{v: 1'b1, tid: exp_last});
         end
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({bus.issue_valid, bus.tid_f} !== e) begin
            n_bad++;
            $display("FAIL stall_seq[%0d] got v=%b tid=%0d want v=%b tid=%0d", j, bus.issue_valid, bus.tid_f, e.v, e.tid);
         end
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_single_thread();
      exp_t e;
      int mc;
      logic pv, stl;
      idle_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      bus.start = 1'b1;
      bus.start_mask = 8'h01;
      step();
      bus.start = 1'b0;
      bus.start_mask = 8'h00;
      n_cmp++; if (bus.active_mask !== 8'h01) begin n_bad++; $display("FAIL one_active got=%h want=01", bus.active_mask); end
      mc = 0;
      pv = 1'b0;
      for (int j = 0; j < 22; j++) begin
         stl = (j >= 12 && j < 16);
         bus.stall = stl;
         if (!stl) begin
            if (mc == 0) begin pv = 1'b1; mc = 4; end
            else begin pv = 1'b0; mc = mc - 1; end
         end
         sb.push_back('{v: pv, tid: 3'd0});
         step();
         e = sb.pop_front();
         n_cmp++;
         if ({bus.issue_valid, bus.tid_f} !== e) begin
            n_bad++;
            $display("FAIL one_seq[%0d] got v=%b tid=%0d want v=%b tid=%0d", j, bus.issue_valid, bus.tid_f, e.v, e.tid);
         end
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_halt_restart();
      exp_t e;
      bus.block_valid = 1'b1; bus.block_tid = 3'd2;
      bus.wake_valid  = 1'b1; bus.wake_tid  = 3'd2;
      step();
      bus.block_valid = 1'b0;
      bus.wake_tid = 3'd1;
      n_cmp++; if (bus.blocked_mask !== 8'h04) begin n_bad++; $display("FAIL blk_wake_same got=%h want=04", bus.blocked_mask); end
      step();
      bus.wake_valid = 1'b0;
      n_cmp++; if (bus.blocked_mask !== 8'h04) begin n_bad++; $display("FAIL wake_unblocked got=%h want=04", bus.blocked_mask); end
      bus.halt_valid = 1'b1; bus.halt_tid = 3'd0;
      step();
      bus.halt_valid = 1'b0;
      n_cmp++; if (bus.active_mask !== 8'h00) begin n_bad++; $display("FAIL halt_active got=%h want=00", bus.active_mask); end
      n_cmp++; if (bus.all_halted !== 1'b1) begin n_bad++; $display("FAIL halt_done got=%b want=1", bus.all_halted); end
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL halt_issue got=%b want=0", bus.issue_valid); end
      bus.start = 1'b1; bus.start_mask = 8'h00;
      bus.halt_valid = 1'b1; bus.halt_tid = 3'd5;
      step();
      bus.start = 1'b0; bus.halt_valid = 1'b0;
      n_cmp++; if (bus.all_halted !== 1'b1) begin n_bad++; $display("FAIL start0_ignored got=%b want=1", bus.all_halted); end
      n_cmp++; if (bus.active_mask !== 8'h00) begin n_bad++; $display("FAIL halt_inactive got=%h want=00", bus.active_mask); end
      step();
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL done_issue got=%b want=0", bus.issue_valid); end
      bus.start = 1'b1; bus.start_mask = 8'h10;
      step();
      bus.start = 1'b0; bus.start_mask = 8'h00;
      n_cmp++; if (bus.active_mask !== 8'h10) begin n_bad++; $display("FAIL restart_active got=%h want=10", bus.active_mask); end
      n_cmp++; if (bus.all_halted !== 1'b0) begin n_bad++; $display("FAIL restart_run got=%b want=0", bus.all_halted); end
      sb.push_back('{v: 1'b1, tid: 3'd4});
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.issue_valid, bus.tid_f} !== e) begin
         n_bad++;
         $display("FAIL restart_first got v=%b tid=%0d want v=%b tid=%0d", bus.issue_valid, bus.tid_f, e.v, e.tid);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.tid_f !== 3'd0) begin n_bad++; $display("FAIL arst_tid got=%0d want=0", bus.tid_f); end
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL arst_issue got=%b want=0", bus.issue_valid); end
      n_cmp++; if (bus.active_mask !== 8'h00) begin n_bad++; $display("FAIL arst_active got=%h want=00", bus.active_mask); end
      n_cmp++; if (bus.blocked_mask !== 8'h00) begin n_bad++; $display("FAIL arst_blocked got=%h want=00", bus.blocked_mask); end
      n_cmp++; if (bus.all_halted !== 1'b0) begin n_bad++; $display("FAIL arst_halted got=%b want=0", bus.all_halted); end
      #10;
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         n_cmp++;
         if (bus.issue_valid !== 1'b0 || bus.active_mask !== 8'h00) begin
            n_bad++;
            $display("FAIL arst_idle[%0d] got v=%b act=%h want v=0 act=00", j, bus.issue_valid, bus.active_mask);
         end
      end
      bus.start = 1'b1; bus.start_mask = 8'hFF;
      step();
      bus.start = 1'b0; bus.start_mask = 8'h00;
      sb.push_back('{v: 1'b1, tid: 3'd0});
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.issue_valid, bus.tid_f} !== e) begin
         n_bad++;
         $display("FAIL arst_restart got v=%b tid=%0d want v=%b tid=%0d", bus.issue_valid, bus.tid_f, e.v, e.tid);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_block_wake();
      test_stall();
      test_single_thread();
      test_halt_restart();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
